en_reg_arbiter: RTL and testbench

//   Round-robin arbiter that shares one enabled D-register (en=1 loads d, en=0 clears q to 0 next edge)

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 32 +++
 rtl/en_reg_arbiter.sv | 107 ++++++++++
 tb/tb_en_reg_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the enabled-register arbiter
// FSM state encodings plus index-width and modular-add helpers.
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Finds the first set request bit searching upward from start, wrapping at N_REQ-1.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] start,
  output logic                    found,
  output logic [idx_w(N_REQ)-1:0] idx
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] w_pos;

  // Walk from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = IW'(wrap_add(int'(start), k, N_REQ));
      if (req[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/en_reg_arbiter.sv
// rtl/en_reg_arbiter.sv - round-robin owner of a shared enabled D-register
// Grants one requester at a time, bounds contended ownership, drives the register en/d pins.
module en_reg_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WIDTH-1:0]  data,
  output logic [N_REQ-1:0]        grant,
  output logic [idx_w(N_REQ)-1:0] owner_id,
  output logic                    busy,
  output logic                    reg_en,
  output logic [WIDTH-1:0]        reg_d
);

  localparam int              IW       = idx_w(N_REQ);
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_REQ - 1);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]    r_owner, w_owner_nxt;
  logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [HW-1:0]    r_hold_cnt, w_hold_nxt;

  logic [N_REQ-1:0] w_cand;
  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic             w_owner_req;
  logic             w_take;

  // While owning, rr_ptr already equals owner+1, so one picker serves both states.
  assign w_cand      = req & ~r_grant;
  assign w_owner_req = |(req & r_grant);

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (w_cand),
    .start(r_rr_ptr),
    .found(w_found),
    .idx  (w_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_hold_nxt   = r_hold_cnt;
    w_take       = 1'b0;

    if (r_state == ST_IDLE) begin
      w_take = w_found;
    end else if (!w_owner_req) begin
      if (w_found) begin
        w_take = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
        w_hold_nxt  = '0;
      end
    end else if (r_hold_cnt == HOLD_MAX && w_found) begin
      w_take = 1'b1;
    end else if (r_hold_cnt != HOLD_MAX) begin
      w_hold_nxt = r_hold_cnt + HW'(1);
    end

    if (w_take) begin
      w_state_nxt  = ST_OWN;
      w_owner_nxt  = w_pick;
      w_grant_nxt  = N_REQ'(1) << w_pick;
      w_hold_nxt   = HW'(1);
      w_rr_ptr_nxt = (w_pick == LAST_IDX) ? '0 : w_pick + IW'(1);
    end
  end

  assign grant    = r_grant;
  assign owner_id = r_owner;
  assign busy     = |r_grant;
  assign reg_en   = busy;
  assign reg_d    = busy ? data[int'(r_owner)*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_en_reg_arbiter.sv
// tb/tb_en_reg_arbiter.sv - self-checking bench for en_reg_arbiter
// Table vectors feed a scoreboard queue; hand sequences cover reset and hold saturation.
module tb_en_reg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [1:0]  owner_id;
  logic        busy;
  logic        reg_en;
  logic [7:0]  reg_d;
  logic [7:0]  q;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [7:0]  q;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] reg_d;
    logic [7:0] q;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  localparam logic [31:0] D = 32'h4433_A511;

  en_reg_arbiter #(
    .N_REQ   (4),
    .WIDTH   (8),
    .MAX_HOLD(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .owner_id(owner_id),
    .busy    (busy),
    .reg_en  (reg_en),
    .reg_d   (reg_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared enabled register: en=1 loads d, en=0 clears.
  always @(posedge clk or posedge rst) begin
    if (rst) q <= 8'h00;
    else     q <= reg_en ? reg_d : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("onehot0_grant", 32'($onehot0(grant)), 32'd1);
      check("reg_en_eq_busy", 32'(reg_en), 32'(busy));
      check("busy_eq_or_grant", 32'(busy), 32'(|grant));
      if (!busy) check("reg_d_zero_idle", 32'(reg_d), 32'd0);
    end
  end

  function automatic void add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g,
                              input logic [1:0] o, input logic [7:0] qq);
    vec_t v;
    v.req = r; v.data = d; v.grant = g; v.owner = o; v.q = qq;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    req     = v.req;
    data    = v.data;
    e.grant = v.grant;
    e.owner = v.owner;
    e.busy  = |v.grant;
    e.reg_d = (|v.grant) ? v.data[int'(v.owner)*8 +: 8] : 8'h00;
    e.q     = v.q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("owner_id", 32'(owner_id), 32'(e.owner));
      check("busy", 32'(busy), 32'(e.busy));
      check("reg_en", 32'(reg_en), 32'(e.busy));
      check("reg_d", 32'(reg_d), 32'(e.reg_d));
      check("q", 32'(q), 32'(e.q));
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(vecs[i]);
  endtask

  initial begin
    int m1, m2;
    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;

    // Single requester, then a grant to requester 2 for the reset test.
    add(4'b0010, D, 4'b0010, 2'd1, 8'h00);
    add(4'b0010, D, 4'b0010, 2'd1, 8'hA5);
    add(4'b0010, D, 4'b0010, 2'd1, 8'hA5);
    add(4'b0000, D, 4'b0000, 2'd0, 8'hA5);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h00);
    add(4'b0100, D, 4'b0100, 2'd2, 8'h00);
    m1 = vecs.size();
    // Rotation with each owner dropping after one cycle and re-raising.
    add(4'b1111, D, 4'b0001, 2'd0, 8'h00);
    add(4'b1110, D, 4'b0010, 2'd1, 8'h11);
    add(4'b1101, D, 4'b0100, 2'd2, 8'hA5);
    add(4'b1011, D, 4'b1000, 2'd3, 8'h33);
    add(4'b0111, D, 4'b0001, 2'd0, 8'h44);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h11);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h00);
    // Wrap from owner 3 to 0 then 1.
    add(4'b1000, D, 4'b1000, 2'd3, 8'h00);
    add(4'b0011, D, 4'b0001, 2'd0, 8'h44);
    add(4'b0010, D, 4'b0010, 2'd1, 8'h11);
    add(4'b0000, D, 4'b0000, 2'd0, 8'hA5);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h00);
    // Forced release after MAX_HOLD=4 owned cycles.
    add(4'b0001, D, 4'b0001, 2'd0, 8'h00);
    add(4'b0101, D, 4'b0001, 2'd0, 8'h11);
    add(4'b0101, D, 4'b0001, 2'd0, 8'h11);
    add(4'b0101, D, 4'b0001, 2'd0, 8'h11);
    add(4'b0101, D, 4'b0100, 2'd2, 8'h11);
    add(4'b0001, D, 4'b0001, 2'd0, 8'h33);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h11);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h00);
    // Owner data changing while owned.
    add(4'b0010, 32'h0000_0100, 4'b0010, 2'd1, 8'h00);
    add(4'b0010, 32'h0000_0200, 4'b0010, 2'd1, 8'h02);
    add(4'b0000, 32'h0000_0300, 4'b0000, 2'd0, 8'h03);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h00);
    // Uncontended long hold by requester 3.
    add(4'b1000, D, 4'b1000, 2'd3, 8'h00);
    for (int i = 0; i < 19; i++) add(4'b1000, D, 4'b1000, 2'd3, 8'h44);
    m2 = vecs.size();
    // Saturated counter: a new contender takes over on the very next edge.
    add(4'b1001, D, 4'b0001, 2'd0, 8'h44);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h11);
    add(4'b0000, D, 4'b0000, 2'd0, 8'h00);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_owner_id", 32'(owner_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_en", 32'(reg_en), 32'd0);
    check("rst_reg_d", 32'(reg_d), 32'd0);
    check("rst_q", 32'(q), 32'd0);

    run_range(0, m1);

    // Asynchronous reset mid-ownership: outputs clear before the next edge.
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_reg_en", 32'(reg_en), 32'd0);
    check("async_rst_reg_d", 32'(reg_d), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_owner", 32'(owner_id), 32'd0);
    req = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;

    run_range(m1, m2);
    check("hold_cnt_saturated", 32'(dut.r_hold_cnt), 32'd4);
    run_range(m2, vecs.size());

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
